id_ex_stage: RTL

//  ID->EX pipeline register of the 5-stage CPU. Captures operands read from the register file plus decoded

---
 rtl/id_ex_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection; 1-cycle latency, hold freezes EX, stall holds PC/IF-ID.
// Optional WB write-through bypass for same-edge register-file write/read collisions: define WB_BYPASS_EN.
module id_ex_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_dst,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              wb_wr,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic              ex_reg_wr,
  output logic              ex_mem_rd,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              reg_wr;
    logic              mem_rd;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        dst;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  ex_reg_t          ld_val;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             ex_is_load;
  logic             hz_rs;
  logic             hz_rt;
  logic [CNT_W-1:0] cnt_q;

  // Only a live load with a non-zero destination can create a load-use hazard.
  assign ex_is_load = ex_q.valid & ex_q.mem_rd & ex_q.reg_wr & (ex_q.dst != 5'd0);
  assign hz_rs      = id_use_rs & (id_rs == ex_q.dst);
  assign hz_rt      = id_use_rt & (id_rt == ex_q.dst);
  assign stall      = ex_is_load & id_valid & ~flush & (hz_rs | hz_rt);

`ifdef WB_BYPASS_EN
  logic byp_rs;
  logic byp_rt;
  assign byp_rs = wb_wr & (wb_addr != 5'd0) & (wb_addr == id_rs);
  assign byp_rt = wb_wr & (wb_addr != 5'd0) & (wb_addr == id_rt);
  assign rs_val = byp_rs ? wb_data : id_rs_data;
  assign rt_val = byp_rt ? wb_data : id_rt_data;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr, wb_addr, wb_data};
  assign rs_val    = id_rs_data;
  assign rt_val    = id_rt_data;
`endif

  always_comb begin
    ld_val = '0;
    if (id_valid) begin
      ld_val.valid   = 1'b1;
      ld_val.reg_wr  = id_reg_wr;
      ld_val.mem_rd  = id_mem_rd;
      ld_val.ctrl    = id_ctrl;
      ld_val.dst     = id_dst;
      ld_val.rs      = id_rs;
      ld_val.rt      = id_rt;
      ld_val.rs_data = rs_val;
      ld_val.rt_data = rt_val;
      ld_val.imm     = id_imm;
    end
  end

  // Priority hold > flush > stall > load; stall already excludes flush.
  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      if (flush || stall) ex_d = '0;
      else                ex_d = ld_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          cnt_q <= '0;
    else if (stall && !hold && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ex_valid   = ex_q.valid;
  assign ex_reg_wr  = ex_q.reg_wr;
  assign ex_mem_rd  = ex_q.mem_rd;
  assign ex_ctrl    = ex_q.ctrl;
  assign ex_dst     = ex_q.dst;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign stall_cnt  = cnt_q;

endmodule
